// File: rtl/pdm_mic_capture_if.sv
`default_nettype none
// ============================================================================
// pdm_mic_capture_if : write-side link from the PDM capture stage to the
//                      1-bit sample FIFO (data, write strobe, full flag).
// Revision: 1.0
// ============================================================================
interface pdm_mic_capture_if;
   logic fifo_din;
   logic fifo_wr;
   logic fifo_full;

   modport master (
      output fifo_din,
      output fifo_wr,
      input  fifo_full
   );

   modport slave (
      input  fifo_din,
      input  fifo_wr,
      output fifo_full
   );
endinterface
`default_nettype wire

// File: rtl/pdm_mic_capture.sv
`default_nettype none
// ============================================================================
// pdm_mic_capture : PDM mic clock generator, sampler and FIFO writer with a
//                   bounded record FSM. Optional macro: MIC_DATA_SYNC_EN.
// Revision: 1.0
// ============================================================================
module pdm_mic_capture #(
   parameter int CLK_DIV  = 50,
   parameter int CNT_BITS = 24,
   parameter int NSAMPLES = 1000000
) (
   input  wire logic                clk_i,
   input  wire logic                rst_ni,
   input  wire logic                start_i,
   input  wire logic                stop_i,
   input  wire logic                mic_data_i,
   pdm_mic_capture_if.master        fifo_o,
   output logic                     mic_clk_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     overflow_o,
   output logic [CNT_BITS-1:0]      sample_cnt_o
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_BITS-1:0] N_LAST   = CNT_BITS'(NSAMPLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q,   state_d;
   logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
   logic                mic_clk_q, mic_clk_d;
   logic                start_q,   start_d;
   logic                din_q,     din_d;
   logic                wr_q,      wr_d;
   logic                wr_hold_q, wr_hold_d;
   logic                busy_q,    busy_d;
   logic                done_q,    done_d;
   logic                ovf_q,     ovf_d;
   logic [CNT_BITS-1:0] cnt_q,     cnt_d;

   logic                div_end;
   logic                sample_evt;
   logic                start_rise;
   logic [CNT_BITS-1:0] cnt_inc;
   logic                mic_data_s;

`ifdef MIC_DATA_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], mic_data_i};
      end
   end

   assign mic_data_s = sync_q[1];
`else
   assign mic_data_s = mic_data_i;
`endif

   always_comb begin
      div_end    = (div_cnt_q == DIV_LAST);
      // Last cycle of the mic_clk high phase: one event per mic_clk period.
      sample_evt = div_end & mic_clk_q;
      start_rise = start_i & ~start_q;
      cnt_inc    = cnt_q + 1'b1;

      state_d    = state_q;
      div_cnt_d  = div_end ? '0 : div_cnt_q + 1'b1;
      mic_clk_d  = mic_clk_q ^ div_end;
      start_d    = start_i;
      din_d      = din_q;
      wr_d       = wr_q;
      wr_hold_d  = wr_hold_q;
      busy_d     = busy_q;
      done_d     = done_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;

      // A started pulse always runs its two cycles, regardless of FSM state.
      if (wr_q) begin
         if (wr_hold_q) begin
            wr_hold_d = 1'b0;
         end else begin
            wr_d = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         ST_RUN: begin
            if (stop_i) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (sample_evt && fifo_o.fifo_full) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ovf_d   = 1'b1;
            end else if (sample_evt) begin
               din_d     = mic_data_s;
               wr_d      = 1'b1;
               wr_hold_d = 1'b1;
               cnt_d     = cnt_inc;
               if (cnt_inc == N_LAST) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         mic_clk_q <= 1'b0;
         start_q   <= 1'b0;
         din_q     <= 1'b0;
         wr_q      <= 1'b0;
         wr_hold_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         mic_clk_q <= mic_clk_d;
         start_q   <= start_d;
         din_q     <= din_d;
         wr_q      <= wr_d;
         wr_hold_q <= wr_hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   assign fifo_o.fifo_din = din_q;
   assign fifo_o.fifo_wr  = wr_q;
   assign mic_clk_o       = mic_clk_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign overflow_o      = ovf_q;
   assign sample_cnt_o    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_mic_capture.sv
`default_nettype none
// ============================================================================
// tb_pdm_mic_capture : scoreboard bench; stimulus queues expected FIFO writes,
//                      a negedge monitor checks each write pulse as it occurs.
// Revision: 1.0
// ============================================================================
module tb_pdm_mic_capture;

   localparam int CLK_DIV  = 4;
   localparam int CNT_BITS = 8;
   localparam int NSAMPLES = 8;

   logic                clk_i      = 1'b0;
   logic                rst_ni     = 1'b0;
   logic                start_i    = 1'b0;
   logic                stop_i     = 1'b0;
   logic                mic_data_i = 1'b0;
   logic                mic_clk_o;
   logic                busy_o;
   logic                done_o;
   logic                overflow_o;
   logic [CNT_BITS-1:0] sample_cnt_o;

   pdm_mic_capture_if fifo_if ();

   pdm_mic_capture #(
      .CLK_DIV  (CLK_DIV),
      .CNT_BITS (CNT_BITS),
      .NSAMPLES (NSAMPLES)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .mic_data_i   (mic_data_i),
      .fifo_o       (fifo_if),
      .mic_clk_o    (mic_clk_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .overflow_o   (overflow_o),
      .sample_cnt_o (sample_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic din;
      logic chk_gap;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic push(input logic din, input logic chk_gap);
      exp_t e;
      e.din     = din;
      e.chk_gap = chk_gap;
      exp_q.push_back(e);
   endtask

   // ---------------- monitor ----------------
   logic m_prev_wr   = 1'b0;
   logic m_last_din  = 1'b0;
   int   m_width     = 0;
   int   m_cyc       = 0;
   int   m_last_rise = 0;
   int   m_hold_left = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk_i);
         m_cyc++;
         if (!rst_ni) begin
            m_prev_wr   = 1'b0;
            m_width     = 0;
            m_hold_left = 0;
         end else begin
            if (m_hold_left > 0 && !fifo_if.fifo_wr) begin
               check("din_hold", fifo_if.fifo_din, m_last_din);
               m_hold_left--;
            end
            if (fifo_if.fifo_wr && !m_prev_wr) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_wr: got a write pulse, expected none (din=%0d)",
                           fifo_if.fifo_din);
                  m_last_din = fifo_if.fifo_din;
               end else begin
                  e = exp_q.pop_front();
                  check("fifo_din", fifo_if.fifo_din, e.din);
                  if (e.chk_gap) check("wr_spacing", m_cyc - m_last_rise, 2 * CLK_DIV);
                  m_last_din = e.din;
               end
               m_last_rise = m_cyc;
               m_width     = 1;
               m_hold_left = 0;
            end else if (fifo_if.fifo_wr && m_prev_wr) begin
               m_width++;
            end else if (!fifo_if.fifo_wr && m_prev_wr) begin
               check("wr_width", m_width, 2);
               m_hold_left = 2;
            end
            m_prev_wr = fifo_if.fifo_wr;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_mic_edge(input logic to_level, input string name);
      logic prev;
      prev = mic_clk_o;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_i);
         if (mic_clk_o == to_level && prev != to_level) return;
         prev = mic_clk_o;
      end
      fail_now(name);
   endtask

   task automatic measure_half();
      logic prev;
      int   n;
      prev = mic_clk_o;
      n    = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (mic_clk_o == prev && n < 20);
      check("mic_half_period", n, CLK_DIV);
   endtask

   // Start is raised right after a mic_clk fall, so RUN is entered early in
   // the low phase and the first write lands at the end of that period.
   task automatic begin_capture(input logic first_bit);
      wait_mic_edge(1'b0, "align_fall");
      start_i    = 1'b1;
      mic_data_i = first_bit;
      @(negedge clk_i);
      start_i = 1'b0;
      check("start_busy", busy_o, 1'b1);
      check("start_done", done_o, 1'b0);
      check("start_cnt", sample_cnt_o, 0);
      check("start_ovf", overflow_o, 1'b0);
   endtask

   task automatic feed(input logic [7:0] pat, input int n, input int again_at);
      begin_capture(pat[0]);
      push(pat[0], 1'b0);
      for (int k = 1; k < n; k++) begin
         wait_mic_edge(1'b0, "mic_fall");
         mic_data_i = pat[k];
         push(pat[k], 1'b1);
         if (k == again_at) start_i = 1'b1;
      end
      wait_mic_edge(1'b0, "mic_fall_last");
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int n = 0; n < 30; n++) begin
         if (done_o) return;
         @(negedge clk_i);
      end
      fail_now(name);
   endtask

   // ---------------- main sequence ----------------
   initial begin : stimulus
      int n;
      fifo_if.fifo_full = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      check("rst_mic_clk", mic_clk_o, 1'b0);
      check("rst_din", fifo_if.fifo_din, 1'b0);
      check("rst_wr", fifo_if.fifo_wr, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_ovf", overflow_o, 1'b0);
      check("rst_cnt", sample_cnt_o, 0);
      for (int i = 0; i < 4; i++) measure_half();

      // Full capture, pattern 1,0,1,1,0,0,1,0
      feed(8'b0100_1101, 8, -1);
      check("full_done", done_o, 1'b1);
      check("full_busy", busy_o, 1'b0);
      check("full_cnt", sample_cnt_o, 8);
      check("full_ovf", overflow_o, 1'b0);

      // Stop after 3 writes
      feed(8'b0000_0101, 3, -1);
      stop_i = 1'b1;
      @(negedge clk_i);
      check("stop_done", done_o, 1'b1);
      check("stop_busy", busy_o, 1'b0);
      check("stop_cnt", sample_cnt_o, 3);
      stop_i = 1'b0;
      repeat (20) @(negedge clk_i);
      check("stop_cnt_hold", sample_cnt_o, 3);

      // FIFO full before the 5th sample event
      feed(8'b0000_1010, 4, -1);
      fifo_if.fifo_full = 1'b1;
      wait_done("ovf_wait_done");
      check("ovf_done", done_o, 1'b1);
      check("ovf_flag", overflow_o, 1'b1);
      check("ovf_cnt", sample_cnt_o, 4);
      check("ovf_busy", busy_o, 1'b0);
      fifo_if.fifo_full = 1'b0;

      // Restart from DONE with a start edge during RUN that must be ignored
      feed(8'b1011_0010, 8, 2);
      check("ign_done", done_o, 1'b1);
      check("ign_cnt", sample_cnt_o, 8);
      check("ign_ovf", overflow_o, 1'b0);

      // Pin step 0->1 one clock before a sample event
      begin_capture(1'b0);
`ifdef MIC_DATA_SYNC_EN
      push(1'b0, 1'b0);
`else
      push(1'b1, 1'b0);
`endif
      wait_mic_edge(1'b1, "sync_rise");
      @(negedge clk_i);
      @(negedge clk_i);
      mic_data_i = 1'b1;
      wait_mic_edge(1'b0, "sync_fall1");
      push(1'b1, 1'b1);
      wait_mic_edge(1'b0, "sync_fall2");
      stop_i = 1'b1;
      @(negedge clk_i);
      stop_i = 1'b0;
      check("sync_cnt", sample_cnt_o, 2);
      check("sync_done", done_o, 1'b1);

      // Async reset in the middle of a write pulse
      begin_capture(1'b1);
      n = 0;
      while (!fifo_if.fifo_wr && n < 40) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      if (n >= 40) begin
         fail_now("rst_mid_wait_wr");
      end else begin
         #1;
         rst_ni = 1'b0;
         #1;
         check("rstmid_wr", fifo_if.fifo_wr, 1'b0);
         check("rstmid_busy", busy_o, 1'b0);
         check("rstmid_done", done_o, 1'b0);
         check("rstmid_cnt", sample_cnt_o, 0);
      end
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (30) @(negedge clk_i);
      check("idle_busy", busy_o, 1'b0);
      check("idle_cnt", sample_cnt_o, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin : watchdog
      #200000;
      fail_now("global_timeout");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
